shared_vc_bank_manager: RTL

//  Per-bank manager of the shared input-VC bank, downstream of the memory bank allocator.

---
 rtl/shared_vc_bank_manager_pkg.sv | 22 ++
 rtl/shared_vc_slot.sv | 83 ++++++++
 rtl/shared_vc_bank_manager.sv | 105 ++++++++++
 3 files changed

// File: rtl/shared_vc_bank_manager_pkg.sv
// Shared package for the shared input-VC bank: VC state encodings,
// vcr-related constants and a clog2 helper for counter sizing.
package shared_vc_bank_manager_pkg;

    localparam int VCR_NUM_PORTS = 5;
    localparam int VCR_VCS_PER_BANK = 2;
    localparam int VCR_BUFFER_SIZE = 8;

    typedef enum logic [1:0] {
        SVC_FREE  = 2'b00,
        SVC_BUSY  = 2'b01,
        SVC_DRAIN = 2'b10
    } svc_state_t;

    function automatic int svc_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/shared_vc_slot.sv
// One shared VC: FREE/BUSY/DRAIN state machine, occupancy counter and
// a per-cycle error pulse (built only with SHARED_BANK_ERR_EN).
// Ports: clk, reset (sync, active-high), alloc (enter BUSY this edge),
//   flit_wr, flit_rd, tail_rd (flit traffic), free/allocated/empty (status),
//   err (error pulse; constant 0 when SHARED_BANK_ERR_EN is undefined).
module shared_vc_slot
    import shared_vc_bank_manager_pkg::*;
#(
    parameter int buffer_size = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic alloc,
    input  logic flit_wr,
    input  logic flit_rd,
    input  logic tail_rd,
    output logic free,
    output logic allocated,
    output logic empty,
    output logic err
);

    localparam int CW = svc_clog2(buffer_size + 1);
    localparam logic [CW-1:0] FULL = CW'(buffer_size);

    svc_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter saturates at FULL and holds at 0; wr+rd together cancel.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({flit_wr, flit_rd})
            2'b10: if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
            2'b01: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SVC_FREE: begin
                if (alloc) state_d = SVC_BUSY;
            end
            SVC_BUSY: begin
                // Tail leaves: free at once if nothing is left behind it.
                if (flit_rd && tail_rd)
                    state_d = (cnt_d == '0) ? SVC_FREE : SVC_DRAIN;
            end
            SVC_DRAIN: begin
                if (cnt_d == '0) state_d = SVC_FREE;
            end
            default: state_d = SVC_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SVC_FREE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign free      = (state_q == SVC_FREE);
    assign allocated = (state_q != SVC_FREE);
    assign empty     = (cnt_q == '0);

`ifdef SHARED_BANK_ERR_EN
    always_comb begin
        err = 1'b0;
        if (flit_wr && !flit_rd && cnt_q == FULL) err = 1'b1;
        if (flit_rd && !flit_wr && cnt_q == '0) err = 1'b1;
        if (state_q == SVC_FREE && (flit_wr || flit_rd)) err = 1'b1;
        if (state_q == SVC_DRAIN && flit_wr) err = 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/shared_vc_bank_manager.sv
// Per-bank manager of the shared input-VC bank: tracks the owning port,
// grants free shared VCs to it and reports per-VC allocated/empty status.
// Ports: clk, reset (sync, active-high), memory_bank_grant_in,
//   ready_for_allocation, alloc_req -> alloc_gnt/alloc_vc (registered);
//   flit_wr/flit_rd/tail_rd per VC; shared_vc_allocated, shared_ivc_empty,
//   owner_port, bank_err (sticky; tied 0 unless SHARED_BANK_ERR_EN).
module shared_vc_bank_manager
    import shared_vc_bank_manager_pkg::*;
#(
    parameter int num_ports        = 5,
    parameter int num_vcs_per_bank = 2,
    parameter int buffer_size      = 8,
    parameter int bank_id          = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [num_ports-1:0]        memory_bank_grant_in,
    input  logic                        ready_for_allocation,
    input  logic [num_ports-1:0]        alloc_req,
    output logic [num_ports-1:0]        alloc_gnt,
    output logic [num_vcs_per_bank-1:0] alloc_vc,
    input  logic [num_vcs_per_bank-1:0] flit_wr,
    input  logic [num_vcs_per_bank-1:0] flit_rd,
    input  logic [num_vcs_per_bank-1:0] tail_rd,
    output logic [num_vcs_per_bank-1:0] shared_vc_allocated,
    output logic [num_vcs_per_bank-1:0] shared_ivc_empty,
    output logic [num_ports-1:0]        owner_port,
    output logic                        bank_err
);

    localparam logic [num_ports-1:0] RST_OWNER = num_ports'(1) << bank_id;

    logic [num_ports-1:0]        owner_q;
    logic [num_ports-1:0]        gnt_q;
    logic [num_vcs_per_bank-1:0] vc_q;
    logic [num_vcs_per_bank-1:0] free;
    logic [num_vcs_per_bank-1:0] pick;
    logic [num_vcs_per_bank-1:0] alloc;
    logic [num_vcs_per_bank-1:0] slot_err;
    logic                        elig;

    // Lowest-index FREE VC, one-hot.
    always_comb begin
        pick = '0;
        for (int v = num_vcs_per_bank - 1; v >= 0; v--) begin
            if (free[v]) begin
                pick    = '0;
                pick[v] = 1'b1;
            end
        end
    end

    // ~|gnt_q enforces an idle cycle between grants, giving the requester
    // time to drop alloc_req after seeing its grant.
    assign elig = ready_for_allocation & (|(alloc_req & owner_q))
                & ~(|gnt_q) & (|free);
    assign alloc = pick & {num_vcs_per_bank{elig}};

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= RST_OWNER;
            gnt_q   <= '0;
            vc_q    <= '0;
        end else begin
            // Ownership only moves once the bank is completely free.
            if (&free) owner_q <= memory_bank_grant_in;
            gnt_q <= elig ? owner_q : '0;
            vc_q  <= alloc;
        end
    end

    for (genvar v = 0; v < num_vcs_per_bank; v++) begin : g_slot
        shared_vc_slot #(
            .buffer_size(buffer_size)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .alloc     (alloc[v]),
            .flit_wr   (flit_wr[v]),
            .flit_rd   (flit_rd[v]),
            .tail_rd   (tail_rd[v]),
            .free      (free[v]),
            .allocated (shared_vc_allocated[v]),
            .empty     (shared_ivc_empty[v]),
            .err       (slot_err[v])
        );
    end

`ifdef SHARED_BANK_ERR_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else if (|slot_err) err_q <= 1'b1;
    end
    assign bank_err = err_q;
`else
    // Slot error outputs are constant 0 in this build.
    assign bank_err = |slot_err;
`endif

    assign alloc_gnt  = gnt_q;
    assign alloc_vc   = vc_q;
    assign owner_port = owner_q;

endmodule
